// File: rtl/rv_bram_arbiter.sv
// Arbiter sharing one single-port fixed-latency BRAM between instruction fetch and data access.
// Data has priority, a starvation guard protects fetch, and a tag pipeline routes read responses.
module rv_bram_arbiter #(
    parameter int LAT    = 2,
    parameter int AW     = 32,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    input  logic          if_flush,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    localparam int CW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE);

    logic [CW-1:0]  starve_q, starve_d;
    logic [LAT-1:0] vld_q, vld_d;
    logic [LAT-1:0] own_q, own_d;   // 0 = fetch, 1 = data
    logic           rd_gnt;
    logic           unused_addr_lsbs;

    assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (if_req && (starve_q == STARVE_MAX)) begin
            if_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end else if (if_req) begin
            if_gnt = 1'b1;
        end
    end

    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr  = d_addr[AW-1:2];
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr[AW-1:2];
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (if_gnt || !if_req) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    assign rd_gnt = if_gnt | (d_gnt & ~d_we);

    // A flush kills fetch entries as they shift; the new entry in stage 0 is the redirect target.
    always_comb begin
        vld_d    = '0;
        own_d    = '0;
        vld_d[0] = rd_gnt;
        own_d[0] = d_gnt;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1] & ~(if_flush & ~own_q[i-1]);
            own_d[i] = own_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            vld_q    <= '0;
            own_q    <= '0;
        end else begin
            starve_q <= starve_d;
            vld_q    <= vld_d;
            own_q    <= own_d;
        end
    end

    always_comb begin
        if_rvalid = vld_q[LAT-1] & ~own_q[LAT-1] & ~if_flush;
        d_rvalid  = vld_q[LAT-1] & own_q[LAT-1];
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        d_rdata   = d_rvalid ? mem_rdata : 32'h0;
        busy      = |vld_q;
    end

endmodule

// File: tb/tb_rv_bram_arbiter.sv
// Directed bench for rv_bram_arbiter: BRAM model, transaction-level reference model, per-cycle compare.
module tb_rv_bram_arbiter;

    localparam int LAT    = 2;
    localparam int AW     = 32;
    localparam int STARVE = 4;
    localparam int LAST_CYC = 70;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_flush, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [31:0]   d_wdata;
    logic          if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy;
    logic [31:0]   if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-3:0] mem_addr;

    rv_bram_arbiter #(.LAT(LAT), .AW(AW), .STARVE(STARVE)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_flush(if_flush),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            4:       return 32'hDEADBEEF;
            8:       return 32'h11111111;
            9:       return 32'h22222222;
            10:      return 32'h33333333;
            11:      return 32'h44444444;
            default: return 32'h1000_0000 + i;
        endcase
    endfunction

    // BRAM: fixed-latency read, write at end of grant cycle
    logic [31:0] bram [0:255];
    logic [31:0] rpipe [LAT];
    always @(posedge clk) begin
        if (mem_en && mem_we) bram[mem_addr[7:0]] <= mem_wdata;
        rpipe[0] <= bram[mem_addr[7:0]];
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[LAT-1];

    // Reference model: outstanding reads with their due cycle, owner and expected data
    typedef struct {
        int          due;
        bit          own;
        logic [31:0] data;
    } rsp_t;
    rsp_t        q[$];
    int          m_starve = 0;
    logic [31:0] ref_mem [0:255];
    int          n_chk = 0;
    int          n_fail = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            bram[i]    = init_word(i);
            ref_mem[i] = init_word(i);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    bit          eg_if, eg_d, e_ifv, e_dv, e_busy;
    logic [31:0] e_ifd, e_dd, e_addr, e_wdata;
    rsp_t        nr;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_starve = 0;
        end
        eg_if = 0;
        eg_d  = 0;
        if (if_req && m_starve == STARVE) eg_if = 1;
        else if (d_req)                   eg_d  = 1;
        else if (if_req)                  eg_if = 1;
        e_addr  = eg_d ? (d_addr >> 2) : (eg_if ? (if_addr >> 2) : 32'h0);
        e_wdata = eg_d ? d_wdata : 32'h0;
        e_busy  = (q.size() != 0);
        if (if_flush) begin
            for (int i = q.size() - 1; i >= 0; i--)
                if (!q[i].own) q.delete(i);
        end
        e_ifv = 0; e_dv = 0; e_ifd = 0; e_dd = 0;
        if (q.size() != 0 && q[0].due == cyc) begin
            if (q[0].own) begin e_dv = 1; e_dd = q[0].data; end
            else          begin e_ifv = 1; e_ifd = q[0].data; end
            void'(q.pop_front());
        end

        chk("if_gnt", {31'b0, if_gnt}, {31'b0, eg_if});
        chk("d_gnt", {31'b0, d_gnt}, {31'b0, eg_d});
        chk("mem_en", {31'b0, mem_en}, {31'b0, eg_if | eg_d});
        chk("mem_we", {31'b0, mem_we}, {31'b0, eg_d & d_we});
        chk("mem_addr", {2'b0, mem_addr}, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, e_ifv});
        chk("if_rdata", if_rdata, e_ifd);
        chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, e_dv});
        chk("d_rdata", d_rdata, e_dd);
        chk("busy", {31'b0, busy}, {31'b0, e_busy});

        case (cyc)
            1:  begin chk("pin_rst_busy", {31'b0, busy}, 32'd0);
                      chk("pin_rst_ifv", {31'b0, if_rvalid}, 32'd0); end
            3:  chk("pin_wr_we", {31'b0, mem_we}, 32'd1);
            5:  begin chk("pin_if_gnt5", {31'b0, if_gnt}, 32'd1);
                      chk("pin_no_wr_rvalid", {31'b0, d_rvalid}, 32'd0); end
            6:  begin chk("pin_d_rvalid6", {31'b0, d_rvalid}, 32'd1);
                      chk("pin_d_rdata6", d_rdata, 32'h7);
                      chk("pin_busy6", {31'b0, busy}, 32'd1); end
            7:  begin chk("pin_if_rvalid7", {31'b0, if_rvalid}, 32'd1);
                      chk("pin_if_rdata7", if_rdata, 32'hDEADBEEF);
                      chk("pin_busy7", {31'b0, busy}, 32'd1); end
            8:  begin chk("pin_busy8", {31'b0, busy}, 32'd0);
                      chk("pin_if_rvalid8", {31'b0, if_rvalid}, 32'd0); end
            12: begin chk("pin_d_rvalid12", {31'b0, d_rvalid}, 32'd1);
                      chk("pin_d_rdata12", d_rdata, 32'h11111111); end
            13: chk("pin_flushed13", {31'b0, if_rvalid}, 32'd0);
            22: begin chk("pin_rst22_ifv", {31'b0, if_rvalid}, 32'd0);
                      chk("pin_rst22_busy", {31'b0, busy}, 32'd0); end
            23: chk("pin_rst23_dv", {31'b0, d_rvalid}, 32'd0);
            32: chk("pin_flush32", {31'b0, if_rvalid}, 32'd0);
            33: chk("pin_flush33", {31'b0, if_rvalid}, 32'd0);
            34: begin chk("pin_redir34", {31'b0, if_rvalid}, 32'd1);
                      chk("pin_redir34_data", if_rdata, 32'h44444444); end
            43: chk("pin_starve_d43", {31'b0, d_gnt}, 32'd1);
            44: chk("pin_starve_if44", {31'b0, if_gnt}, 32'd1);
            45: chk("pin_d_rvalid45", {31'b0, d_rvalid}, 32'd1);
            46: begin chk("pin_if_rvalid46", {31'b0, if_rvalid}, 32'd1);
                      chk("pin_if_rdata46", if_rdata, 32'hDEADBEEF); end
            49: chk("pin_starve_if49", {31'b0, if_gnt}, 32'd1);
            65: begin chk("pin_rw65", {31'b0, if_rvalid}, 32'd1);
                      chk("pin_rw65_data", if_rdata, 32'hCAFEF00D); end
            default: ;
        endcase

        if (rst_n) begin
            if (eg_if || (eg_d && !d_we)) begin
                nr.due  = cyc + LAT;
                nr.own  = eg_d;
                nr.data = eg_d ? ref_mem[d_addr[9:2]] : ref_mem[if_addr[9:2]];
                q.push_back(nr);
            end
            if (eg_d && d_we) ref_mem[d_addr[9:2]] = d_wdata;
            if (eg_if || !if_req)     m_starve = 0;
            else if (m_starve < STARVE) m_starve++;
        end else begin
            m_starve = 0;
        end
    end

    task automatic apply(input int c);
        if_req = 0; if_addr = '0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        case (c)
            2:  rst_n = 1;
            3:  begin d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'h7; end
            4:  begin d_req = 1; d_addr = 32'h8; end
            5:  begin if_req = 1; if_addr = 32'h10; end
            10: begin d_req = 1; d_addr = 32'h20; end
            11: begin if_req = 1; if_addr = 32'h24; end
            12: if_flush = 1;
            20: begin if_req = 1; if_addr = 32'h10; end
            21: begin d_req = 1; d_addr = 32'h20; end
            22: rst_n = 0;
            23: rst_n = 1;
            30: begin if_req = 1; if_addr = 32'h24; end
            31: begin if_req = 1; if_addr = 32'h28; end
            32: begin if_req = 1; if_addr = 32'h2C; if_flush = 1; end
            62: begin if_req = 1; if_addr = 32'h24;
                      d_req = 1; d_we = 1; d_addr = 32'h24; d_wdata = 32'hCAFEF00D; end
            63: begin if_req = 1; if_addr = 32'h24; end
            default: if (c >= 40 && c < 60) begin
                if_req = 1; if_addr = 32'h10;
                d_req  = 1; d_addr  = 32'h20;
            end
        endcase
    endtask

    initial begin
        rst_n = 0;
        apply(0);
        while (cyc < LAST_CYC) begin
            @(posedge clk);
            #1;
            apply(cyc);
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
